// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_ctrl_pkg
// Description : Mode encoding and timing constant helpers for led_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'b000,
        MODE_ON      = 3'b001,
        MODE_BLINK   = 3'b010,
        MODE_PWM     = 3'b011,
        MODE_BREATHE = 3'b100
    } mode_t;

    // Cycles in one full blink/breathe period, rounded to the nearest clock.
    function automatic int calc_count(input real clk_freq, input real period);
        return int'(clk_freq * period);
    endfunction

    function automatic int calc_half(input int count);
        return count / 2;
    endfunction

    function automatic int calc_step(input int count, input int pwm_width);
        int s;
        s = count / (1 << (pwm_width + 1));
        return (s < 1) ? 1 : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_ctrl_chan.sv
`default_nettype none
// ============================================================================
// Module      : led_ctrl_chan
// Description : One LED channel: mode register, shadow/active duty, lit decode.
//               Breathe input present only with LED_CTRL_BREATHE_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module led_ctrl_chan
    import led_ctrl_pkg::*;
#(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 wr_sel,
    input  logic [2:0]           wr_mode,
    input  logic [PWM_WIDTH-1:0] wr_duty,
    input  logic [PWM_WIDTH-1:0] pwm_cnt,
    input  logic                 pwm_wrap,
    input  logic                 blink_phase,
`ifdef LED_CTRL_BREATHE_EN
    input  logic [PWM_WIDTH-1:0] breathe_duty,
`endif
    output logic                 lit
);

    mode_t                r_mode;
    logic [PWM_WIDTH-1:0] r_shadow;
    logic [PWM_WIDTH-1:0] r_active;
    logic                 w_lit;

    // Active duty only changes at the period boundary; a write landing on
    // the wrap cycle goes straight to the active register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_mode   <= MODE_OFF;
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (wr_sel) begin
                r_mode   <= mode_t'(wr_mode);
                r_shadow <= wr_duty;
            end
            if (pwm_wrap) begin
                r_active <= wr_sel ? wr_duty : r_shadow;
            end
        end
    end

    always_comb begin
        w_lit = 1'b0;
        case (r_mode)
            MODE_ON:      w_lit = 1'b1;
            MODE_BLINK:   w_lit = blink_phase;
            MODE_PWM:     w_lit = (&r_active) | (pwm_cnt < r_active);
`ifdef LED_CTRL_BREATHE_EN
            MODE_BREATHE: w_lit = (pwm_cnt < breathe_duty);
`endif
            default:      w_lit = 1'b0;
        endcase
    end

    assign lit = w_lit;

endmodule
`default_nettype wire

// File: rtl/led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_ctrl
// Description : Multi-channel LED driver (off/on/blink/PWM, optional breathe
//               via LED_CTRL_BREATHE_EN) with a free-running heartbeat.
// Revision    : 1.0 - initial release
// ============================================================================
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter real CLK_FREQ     = 16.0e6,
    parameter real BLINK_PERIOD = 0.5,
    parameter int  NUM_LEDS     = 8,
    parameter int  PWM_WIDTH    = 8,
    parameter int  ACTIVE_LOW   = 1,
    parameter int  CHAN_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 wr_en,
    input  logic [CHAN_W-1:0]    wr_chan,
    input  logic [2:0]           wr_mode,
    input  logic [PWM_WIDTH-1:0] wr_duty,
    output logic [NUM_LEDS-1:0]  led,
    output logic                 heartbeat
);

    localparam int c_count   = calc_count(CLK_FREQ, BLINK_PERIOD);
    localparam int c_half    = calc_half(c_count);
    localparam int c_blink_w = (c_half > 2) ? $clog2(c_half) : 1;
    localparam int c_chan_min = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(c_half - 1);
    localparam logic [NUM_LEDS-1:0]  c_led_idle   = {NUM_LEDS{ACTIVE_LOW != 0}};

    if (c_half < 2) begin : g_err_half
        $error("led_ctrl: CLK_FREQ*BLINK_PERIOD too small, HALF=%0d", c_half);
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 32) begin : g_err_num_leds
        $error("led_ctrl: NUM_LEDS=%0d outside 1..32", NUM_LEDS);
    end
    if (PWM_WIDTH < 4 || PWM_WIDTH > 12) begin : g_err_pwm_width
        $error("led_ctrl: PWM_WIDTH=%0d outside 4..12", PWM_WIDTH);
    end
    if (CHAN_W < c_chan_min) begin : g_err_chan_w
        $error("led_ctrl: CHAN_W=%0d cannot address %0d channels", CHAN_W, NUM_LEDS);
    end

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_phase;
    logic [PWM_WIDTH-1:0] r_pwm_cnt;
    logic                 w_pwm_wrap;
    logic [NUM_LEDS-1:0]  w_lit;
    logic [NUM_LEDS-1:0]  r_led;

    assign w_pwm_wrap = &r_pwm_cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_pwm_cnt     <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

`ifdef LED_CTRL_BREATHE_EN
    localparam int c_step   = calc_step(c_count, PWM_WIDTH);
    localparam int c_step_w = (c_step > 2) ? $clog2(c_step) : 1;
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(c_step - 1);

    logic [c_step_w-1:0]  r_step_cnt;
    logic [PWM_WIDTH-1:0] r_ramp;
    logic                 r_ramp_down;
    logic [PWM_WIDTH-1:0] r_breathe_duty;

    // Triangle ramp holds one step at each end so up and down legs match.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_step_cnt     <= '0;
            r_ramp         <= '0;
            r_ramp_down    <= 1'b0;
            r_breathe_duty <= '0;
        end else begin
            if (r_step_cnt == c_step_last) begin
                r_step_cnt <= '0;
                if (!r_ramp_down) begin
                    if (&r_ramp) r_ramp_down <= 1'b1;
                    else         r_ramp      <= r_ramp + 1'b1;
                end else begin
                    if (r_ramp == '0) r_ramp_down <= 1'b0;
                    else              r_ramp      <= r_ramp - 1'b1;
                end
            end else begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
            if (w_pwm_wrap) begin
                r_breathe_duty <= r_ramp;
            end
        end
    end
`endif

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        logic w_sel;
        assign w_sel = wr_en && (wr_chan == CHAN_W'(i));

        led_ctrl_chan #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_chan (
            .clk          (clk),
            .rstN         (rstN),
            .wr_sel       (w_sel),
            .wr_mode      (wr_mode),
            .wr_duty      (wr_duty),
            .pwm_cnt      (r_pwm_cnt),
            .pwm_wrap     (w_pwm_wrap),
            .blink_phase  (r_blink_phase),
`ifdef LED_CTRL_BREATHE_EN
            .breathe_duty (r_breathe_duty),
`endif
            .lit          (w_lit[i])
        );
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_led <= c_led_idle;
        end else begin
            r_led <= w_lit ^ c_led_idle;
        end
    end

    assign led       = r_led;
    assign heartbeat = r_blink_phase;

endmodule
`default_nettype wire

// File: tb/tb_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_ctrl
// Description : Directed self-checking bench for led_ctrl (4 channels,
//               HALF=16, 4-bit PWM, active-low pins).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic       wr_en;
    logic [2:0] wr_chan;
    logic [2:0] wr_mode;
    logic [3:0] wr_duty;
    logic [3:0] led;
    logic       heartbeat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    led_ctrl #(
        .CLK_FREQ     (1000.0),
        .BLINK_PERIOD (0.032),
        .NUM_LEDS     (4),
        .PWM_WIDTH    (4),
        .ACTIVE_LOW   (1),
        .CHAN_W       (3)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .wr_en     (wr_en),
        .wr_chan   (wr_chan),
        .wr_mode   (wr_mode),
        .wr_duty   (wr_duty),
        .led       (led),
        .heartbeat (heartbeat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [2:0] ch, input logic [2:0] mode, input logic [3:0] duty);
        wr_en   = 1'b1;
        wr_chan = ch;
        wr_mode = mode;
        wr_duty = duty;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic align();
        while (cyc % 16 != 0) tick();
    endtask

    // One PWM period of led[ch]; optional pwm write to ch at offset wr_at.
    task automatic measure(input int ch, input int wr_at, input logic [3:0] wduty,
                           output int lows, output int first);
        lows  = 0;
        first = -1;
        for (int j = 0; j < 16; j++) begin
            if (j == wr_at) begin
                wr_en   = 1'b1;
                wr_chan = 3'(ch);
                wr_mode = 3'b011;
                wr_duty = wduty;
            end
            tick();
            wr_en = 1'b0;
            if (led[ch] == 1'b0) begin
                if (first < 0) first = j;
                lows++;
            end
        end
    endtask

    initial begin
        int  lows, first, errs;
        logic hb_prev, saw0, saw1;

        rstN = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_mode = '0; wr_duty = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_led", led, 4'b1111);
        chk("reset_hb", heartbeat, 1'b0);
        rstN = 1'b1;
        cyc  = 0;

        repeat (15) tick();
        chk("hb_low_15", heartbeat, 1'b0);
        tick();
        chk("hb_rise_16", heartbeat, 1'b1);
        repeat (15) tick();
        chk("hb_high_31", heartbeat, 1'b1);
        tick();
        chk("hb_fall_32", heartbeat, 1'b0);
        chk("idle_led", led, 4'b1111);

        wr(3'd0, 3'b001, 4'd0);
        chk("on_latency_1clk", led[0], 1'b1);
        wr(3'd1, 3'b010, 4'd0);
        chk("on_latency_2clk", led[0], 1'b0);
        wr(3'd2, 3'b000, 4'd0);
        chk("off_led2", led[2], 1'b1);

        errs = 0; saw0 = 1'b0; saw1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            hb_prev = heartbeat;
            tick();
            if (led[1] !== ~hb_prev) errs++;
            if (led[1] == 1'b0) saw0 = 1'b1; else saw1 = 1'b1;
        end
        chk("blink_tracks_hb", errs, 0);
        chk("blink_toggles", {saw0, saw1}, 2'b11);

        wr(3'd3, 3'b011, 4'd4);
        align();
        measure(3, -1, 4'd0, lows, first);
        chk("pwm4_p1_lows", lows, 4);
        chk("pwm4_p1_first", first, 0);
        measure(3, -1, 4'd0, lows, first);
        chk("pwm4_p2_lows", lows, 4);
        chk("static_leds", {led[2], led[0]}, 2'b10);

        wr(3'd3, 3'b011, 4'd0);
        align();
        measure(3, -1, 4'd0, lows, first);
        chk("pwm0_lows", lows, 0);
        wr(3'd3, 3'b011, 4'd15);
        align();
        measure(3, -1, 4'd0, lows, first);
        chk("pwm15_lows", lows, 16);

        wr(3'd3, 3'b011, 4'd4);
        align();
        measure(3, -1, 4'd0, lows, first);
        chk("glitch_pre_lows", lows, 4);
        measure(3, 5, 4'd12, lows, first);
        chk("glitch_mid_write_cur", lows, 4);
        measure(3, -1, 4'd0, lows, first);
        chk("glitch_next_period", lows, 12);

        measure(3, 3, 4'd4, lows, first);
        chk("wrap_setup_cur", lows, 12);
        measure(3, 15, 4'd12, lows, first);
        chk("wrap_write_cur", lows, 4);
        measure(3, -1, 4'd0, lows, first);
        chk("wrap_write_next", lows, 12);

        wr(3'd1, 3'b001, 4'd0);
        wr(3'd3, 3'b000, 4'd0);
        tick();
        chk("pre_invalid_led", led, 4'b1100);
        wr(3'd5, 3'b000, 4'd0);
        wr(3'd6, 3'b001, 4'd0);
        wr(3'd4, 3'b000, 4'd0);
        wr(3'd7, 3'b001, 4'd0);
        tick();
        tick();
        chk("invalid_chan_led", led, 4'b1100);

        wr(3'd1, 3'b010, 4'd0);
        repeat (20) tick();
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        chk("async_reset_led", led, 4'b1111);
        chk("async_reset_hb", heartbeat, 1'b0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        cyc  = 0;
        repeat (15) tick();
        chk("post_reset_hb_15", heartbeat, 1'b0);
        tick();
        chk("post_reset_hb_16", heartbeat, 1'b1);
        chk("post_reset_modes_off", led, 4'b1111);
        wr(3'd3, 3'b011, 4'd4);
        align();
        measure(3, -1, 4'd0, lows, first);
        chk("post_reset_pwm_lows", lows, 4);
        chk("post_reset_pwm_align", first, 0);

`ifdef LED_CTRL_BREATHE_EN
        wr(3'd0, 3'b100, 4'd0);
        align();
        for (int p = 0; p < 2; p++) begin
            int exp_lows;
            exp_lows = ((cyc / 16) % 2 == 1) ? 15 : 0;
            measure(0, -1, 4'd0, lows, first);
            chk("breathe_period_lows", lows, exp_lows);
        end
`else
        wr(3'd0, 3'b100, 4'd0);
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (led[0] !== 1'b1) errs++;
        end
        chk("breathe_disabled_off", errs, 0);
`endif
        wr(3'd0, 3'b111, 4'd15);
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (led[0] !== 1'b1) errs++;
        end
        chk("mode_111_off", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
